// File: rtl/writeback_arbiter.sv
// ============================================================================
// Module   : writeback_arbiter
// Brief    : Merges ALU and buffered load results onto one register-file write
//            port, with a starvation guard and optional forwarding (WB_FWD_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        AluValid,
  input  logic [4:0]  AluReg,
  input  logic [31:0] AluData,
  input  logic        MemValid,
  output logic        MemReady,
  input  logic [4:0]  MemReg,
  input  logic [31:0] MemData,
  output logic [4:0]  WriteReg1,
  output logic [31:0] WriteData1,
  output logic        Write1,
  output logic        AluHold,
  input  logic [4:0]  QueryReg,
  output logic        FwdHit,
  output logic [31:0] FwdData
);

  localparam int C_AW = $clog2(DEPTH);

  logic [4:0]      fifo_reg_q  [DEPTH];
  logic [31:0]     fifo_data_q [DEPTH];
  logic [C_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_AW:0]   count_q, count_d;
  logic [3:0]      starve_q, starve_d;
  logic            hold_q, hold_d;
  logic            write_q, write_d;
  logic [4:0]      wreg_q, wreg_d;
  logic [31:0]     wdata_q, wdata_d;

  logic            w_empty;
  logic            w_push;
  logic            w_alu_sel;
  logic            w_pop;
  logic [4:0]      w_sel_reg;
  logic [31:0]     w_sel_data;

  assign w_empty    = (count_q == '0);
  assign MemReady   = (count_q != (C_AW+1)'(DEPTH));
  assign w_push     = MemValid && MemReady;
  // A held-off ALU result is dropped so the FIFO head always wins under hold.
  assign w_alu_sel  = AluValid && !hold_q;
  assign w_pop      = !w_alu_sel && !w_empty;
  assign w_sel_reg  = w_alu_sel ? AluReg  : fifo_reg_q[rd_ptr_q];
  assign w_sel_data = w_alu_sel ? AluData : fifo_data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + C_AW'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + C_AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (w_push && !w_pop)
      count_d = count_q + (C_AW+1)'(1);
    else if (!w_push && w_pop)
      count_d = count_q - (C_AW+1)'(1);

    starve_d = starve_q;
    if (w_pop || w_empty)
      starve_d = '0;
    else if (w_alu_sel)
      starve_d = starve_q + 4'd1;
    // Hold drops at the forced-pop edge because the pop clears the counter.
    hold_d = (starve_d == 4'(STARVE_LIMIT));

    write_d = (w_alu_sel || w_pop) && (w_sel_reg != 5'd0);
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (w_alu_sel || w_pop) begin
      wreg_d  = w_sel_reg;
      wdata_d = w_sel_data;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      hold_q   <= 1'b0;
      write_q  <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
      write_q  <= write_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      fifo_reg_q[wr_ptr_q]  <= MemReg;
      fifo_data_q[wr_ptr_q] <= MemData;
    end
  end

  assign Write1     = write_q;
  assign WriteReg1  = wreg_q;
  assign WriteData1 = wdata_q;
  assign AluHold    = hold_q;

`ifdef WB_FWD_EN
  logic [C_AW-1:0] w_idx;

  // Oldest to newest so later matches override; output register beats all.
  always_comb begin
    FwdHit  = 1'b0;
    FwdData = 32'h0;
    w_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = rd_ptr_q + C_AW'(k);
      if (((C_AW+1)'(k) < count_q) && (fifo_reg_q[w_idx] == QueryReg)) begin
        FwdHit  = 1'b1;
        FwdData = fifo_data_q[w_idx];
      end
    end
    if (write_q && (wreg_q == QueryReg)) begin
      FwdHit  = 1'b1;
      FwdData = wdata_q;
    end
    if (QueryReg == 5'd0) begin
      FwdHit  = 1'b0;
      FwdData = 32'h0;
    end
  end
`else
  logic w_unused_query;

  assign w_unused_query = ^QueryReg;
  assign FwdHit         = 1'b0;
  assign FwdData        = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// ============================================================================
// Module   : tb_writeback_arbiter
// Brief    : Directed self-checking bench for writeback_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_writeback_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        AluValid;
  logic [4:0]  AluReg;
  logic [31:0] AluData;
  logic        MemValid;
  logic        MemReady;
  logic [4:0]  MemReg;
  logic [31:0] MemData;
  logic [4:0]  WriteReg1;
  logic [31:0] WriteData1;
  logic        Write1;
  logic        AluHold;
  logic [4:0]  QueryReg;
  logic        FwdHit;
  logic [31:0] FwdData;

  int checks   = 0;
  int failures = 0;

  writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData),
    .MemValid(MemValid), .MemReady(MemReady), .MemReg(MemReg), .MemData(MemData),
    .WriteReg1(WriteReg1), .WriteData1(WriteData1), .Write1(Write1),
    .AluHold(AluHold), .QueryReg(QueryReg), .FwdHit(FwdHit), .FwdData(FwdData)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit hold_exp(input int n);
    return (n == 9) || (n == 18) || (n == 27) || (n == 36);
  endfunction

  function automatic int pop_idx(input int n);
    case (n)
      10: return 1;
      19: return 2;
      28: return 3;
      37: return 4;
      default: return 0;
    endcase
  endfunction

  initial begin
    RESET = 1'b0; AluValid = 1'b0; AluReg = '0; AluData = '0;
    MemValid = 1'b0; MemReg = '0; MemData = '0; QueryReg = '0;
    tick(); tick();
    chk("rst_write1", 32'(Write1), 32'd0);
    chk("rst_wreg", 32'(WriteReg1), 32'd0);
    chk("rst_wdata", WriteData1, 32'd0);
    chk("rst_hold", 32'(AluHold), 32'd0);
    RESET = 1'b1;
    tick();
    chk("rst_memready", 32'(MemReady), 32'd1);
    chk("rst_fwdhit", 32'(FwdHit), 32'd0);

    // Single ALU write
    AluValid = 1'b1; AluReg = 5'd5; AluData = 32'hDEADBEEF;
    tick();
    AluValid = 1'b0;
    chk("alu_write1", 32'(Write1), 32'd1);
    chk("alu_wreg", 32'(WriteReg1), 32'd5);
    chk("alu_wdata", WriteData1, 32'hDEADBEEF);
    tick();
    chk("alu_idle_write1", 32'(Write1), 32'd0);
    chk("alu_idle_hold_data", WriteData1, 32'hDEADBEEF);

    // Starvation guard: four loads under continuous ALU pressure
    AluValid = 1'b1; AluReg = 5'd20; AluData = 32'd100;
    MemValid = 1'b1; MemReg = 5'd1; MemData = 32'h11;
    tick();
    chk("stv_e1_wreg", 32'(WriteReg1), 32'd20);
    MemReg = 5'd2; MemData = 32'h22; tick();
    MemReg = 5'd3; MemData = 32'h33; tick();
    MemReg = 5'd4; MemData = 32'h44; tick();
    chk("stv_full_memready", 32'(MemReady), 32'd0);
    MemValid = 1'b0;
    for (int n = 5; n <= 40; n++) begin
      AluValid = !hold_exp(n - 1);
      tick();
      chk($sformatf("stv_hold_%0d", n), 32'(AluHold), 32'(hold_exp(n)));
      chk($sformatf("stv_write1_%0d", n), 32'(Write1), 32'd1);
      chk($sformatf("stv_memready_%0d", n), 32'(MemReady), 32'(n >= 10));
      if (pop_idx(n) != 0) begin
        chk($sformatf("stv_load_reg_%0d", n), 32'(WriteReg1), 32'(pop_idx(n)));
        chk($sformatf("stv_load_data_%0d", n), WriteData1, 32'(pop_idx(n) * 17));
      end else begin
        chk($sformatf("stv_alu_reg_%0d", n), 32'(WriteReg1), 32'd20);
      end
    end
    AluValid = 1'b0;
    tick();
    chk("stv_done_write1", 32'(Write1), 32'd0);

    // Load to register 0
    MemValid = 1'b1; MemReg = 5'd0; MemData = 32'hFFFFFFFF; QueryReg = 5'd0;
    tick();
    MemValid = 1'b0;
    chk("r0_fwdhit", 32'(FwdHit), 32'd0);
    tick();
    chk("r0_write1", 32'(Write1), 32'd0);
    chk("r0_wdata", WriteData1, 32'hFFFFFFFF);
    chk("r0_memready", 32'(MemReady), 32'd1);

    // Forwarding: two buffered loads to reg 7 behind ALU traffic
    AluValid = 1'b1; AluReg = 5'd9; AluData = 32'h99;
    MemValid = 1'b1; MemReg = 5'd7; MemData = 32'hA;
    tick();
    MemData = 32'hB;
    tick();
    MemValid = 1'b0; QueryReg = 5'd7;
    #1;
`ifdef WB_FWD_EN
    chk("fwd_hit7", 32'(FwdHit), 32'd1);
    chk("fwd_data7", FwdData, 32'hB);
    QueryReg = 5'd9; #1;
    chk("fwd_hit9", 32'(FwdHit), 32'd1);
    chk("fwd_data9", FwdData, 32'h99);
`else
    chk("fwd_off_hit", 32'(FwdHit), 32'd0);
    chk("fwd_off_data", FwdData, 32'h0);
`endif
    QueryReg = 5'd0;
    AluValid = 1'b0;
    tick();
    chk("fwd_pop_a", WriteData1, 32'hA);
    tick();
    chk("fwd_pop_b_reg", 32'(WriteReg1), 32'd7);
    chk("fwd_pop_b", WriteData1, 32'hB);

    // Full FIFO with push attempt during a pop; pointers wrap 3 -> 0
    AluValid = 1'b1; MemValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      MemReg = 5'(11 + i); MemData = 32'h1100 + 32'(i);
      tick();
    end
    chk("wrap_full", 32'(MemReady), 32'd0);
    AluValid = 1'b0; MemReg = 5'd15; MemData = 32'hBAD;
    tick();
    MemValid = 1'b0;
    chk("wrap_pop11", 32'(WriteReg1), 32'd11);
    chk("wrap_ready", 32'(MemReady), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("wrap_reg_%0d", i), 32'(WriteReg1), 32'(11 + i));
      chk($sformatf("wrap_data_%0d", i), WriteData1, 32'h1100 + 32'(i));
    end
    tick();
    chk("wrap_no_extra", 32'(Write1), 32'd0);

    // Asynchronous reset mid-drain with 3 entries buffered
    AluValid = 1'b1; MemValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      MemReg = 5'(21 + i); MemData = 32'h2100 + 32'(i);
      tick();
    end
    MemValid = 1'b0; AluValid = 1'b0;
    chk("mid_pre_write1", 32'(Write1), 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("mid_rst_write1", 32'(Write1), 32'd0);
    chk("mid_rst_memready", 32'(MemReady), 32'd1);
    tick();
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid_post_write1_%0d", i), 32'(Write1), 32'd0);
    end
    chk("mid_post_memready", 32'(MemReady), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage that merges single-cycle ALU results and variable-latency memory (load) results onto the single register-file write port (`WriteReg1`/`WriteData1`/`Write1`). ALU results take priority. Load results are held in a small in-order FIFO with a valid/ready handshake. A starvation guard holds the ALU path off so buffered loads always drain. An optional forwarding port exposes pending, not-yet-committed writes to decode.

## Interface
- `DEPTH`, default 4: load FIFO entries; power of two, minimum 2.
- `STARVE_LIMIT`, default 8: consecutive ALU-won cycles with a non-empty FIFO before `AluHold` asserts; range 1–15.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-low.
- `AluValid`  in  1  ALU result present this cycle; there is no ready signal.
- `AluReg`  in  5  ALU destination register.
- `AluData`  in  32  ALU result.
- `MemValid`  in  1  load result offered.
- `MemReady`  out  1  FIFO can accept; equals `count != DEPTH`.
- `MemReg`  in  5  load destination register.
- `MemData`  in  32  load result.
- `WriteReg1`  out  5  register-file write index (registered).
- `WriteData1`  out  32  register-file write data (registered).
- `Write1`  out  1  register-file write enable (registered).
- `AluHold`  out  1  registered; upstream must not present `AluValid` while it is high.
- `QueryReg`  in  5  decode forwarding lookup index.
- `FwdHit`  out  1  a pending write to `QueryReg` exists.
- `FwdData`  out  32  data of the highest-priority matching pending write.

## Operation
- Push: on a rising edge with `MemValid && MemReady`, `{MemReg, MemData}` is written at the FIFO tail. `MemReady` does not depend on a same-cycle pop, so nothing is pushed while the FIFO is full.
- Source selection each cycle:
  - `AluValid && !AluHold`: the ALU result is selected.
  - Otherwise, if the FIFO is non-empty: the head is popped and selected.
  - Otherwise: nothing is selected.
- `AluValid` while `AluHold=1` is a protocol violation. The ALU result is dropped and the FIFO head wins.
- Output register: on each edge, `Write1` is set to (something selected) AND (selected destination register != 0). `WriteReg1` and `WriteData1` load the selected values. When nothing is selected they hold their previous values.
- Register 0: writes to register 0 are consumed (FIFO popped, ALU accepted) but never raise `Write1`.
- Starvation counter (4 bits):
  - Increments on each edge where the FIFO is non-empty and the ALU won.
  - Clears on any pop or when the FIFO is empty.
  - `AluHold` is set at the edge where the count reaches `STARVE_LIMIT`, and cleared at the edge after the forced pop.
- Ordering: FIFO entries retire strictly in arrival order. Relative order between the ALU and memory sources is not preserved; upstream hazard logic owns that.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits. A simultaneous push and pop leaves `count` unchanged.

## Timing
- ALU latency: sampled at edge N, `Write1` high in cycle N→N+1.
- Load latency (FIFO empty, no ALU traffic): pushed at edge N, popped at edge N+1, `Write1` high in cycle N+1→N+2.
- The register file commits `WriteData1` at the edge following `Write1` high.
- `FwdHit` and `FwdData` are combinational from `QueryReg` and current state.
- Forwarding priority: the output register (when `Write1=1`) first, then FIFO entries newest to oldest. `QueryReg == 0` never hits.
- Reset (asynchronous, any time):
  - `Write1=0`, `WriteReg1=0`, `WriteData1=0`, `AluHold=0`.
  - FIFO emptied (`MemReady=1` once reset releases), starvation counter 0, `FwdHit=0`.
  - In-flight FIFO contents are discarded and no write is issued.

## Configuration
- `WB_FWD_EN` defined: forwarding lookup is implemented as described under Timing.
- `WB_FWD_EN` undefined:
  - `FwdHit` is tied to 0 and `FwdData` to 32'h0.
  - `QueryReg` is ignored and no comparators are built.
  - All other behaviour is identical.

## Test plan
- Reset, then `AluValid=1`, `AluReg=5`, `AluData=32'hDEADBEEF` for one cycle → next cycle `Write1=1`, `WriteReg1=5`, `WriteData1=32'hDEADBEEF`; the cycle after that, `Write1=0`.
- Four loads (regs 1–4, data 32'h11…32'h44) pushed back-to-back while `AluValid` is held high (≥4 cycles, `STARVE_LIMIT=8`) → `MemReady=0` after the 4th push; ALU writes continue until `AluHold` asserts 8 cycles after the first ALU-won cycle with a non-empty FIFO; the guard then repeats until regs 1–4 have been written in order.
- Load to reg 0 with data 32'hFFFFFFFF → FIFO pops, `Write1` stays 0; `FwdHit=0` for `QueryReg=0`.
- With `WB_FWD_EN`: two loads to reg 7 buffered (32'hA, then 32'hB) under ALU pressure, `QueryReg=7` → `FwdHit=1`, `FwdData=32'hB`; with the macro undefined → `FwdHit=0`.
- Full FIFO with simultaneous `MemValid=1` and a pop → no push that cycle, `count` drops to 3, `MemReady=1` the next cycle; the pointer wrap from 3 to 0 retires data intact.
- `RESET` asserted low mid-drain with 3 entries buffered → `Write1=0` immediately; after release, no stale writes appear and `MemReady=1`.
